// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: decoded control bundle, opcodes and ALUOp bit positions.
package riscv_pkg;

  typedef struct packed {
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic [2:0] aluop;
    logic       branch;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] BR     = 7'b1100011;
  localparam logic [6:0] OPIMM  = 7'b0010011;

  // ALUOp is one-hot; all-zero selects the I-type ALU path
  localparam int ALUOP_BR  = 0;
  localparam int ALUOP_R   = 1;
  localparam int ALUOP_MEM = 2;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the instruction in EX and the one in ID.
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_memread,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              ex_flush,
  output logic              haz,
  output logic              stall
);

  // rs2 is matched for every format; an occasional needless stall is harmless
  assign haz   = ex_memread & ex_valid & (ex_rd != '0) &
                 ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  // a taken branch kills the ID instruction, so holding it would be pointless
  assign stall = haz & ~ex_flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches decoded control and operands, inserts bubbles on
// load-use hazards and on branch flushes.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_alusrc,
  input  logic              id_memtoreg,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic [2:0]        id_aluop,
  input  logic              id_branch,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [2:0]        id_funct3,
  input  logic [6:0]        id_funct7,
  input  logic              ex_flush,
  output logic              stall,
  output logic              ex_valid,
  output logic              ex_alusrc,
  output logic              ex_memtoreg,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic [2:0]        ex_aluop,
  output logic              ex_branch,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [2:0]        ex_funct3,
  output logic [6:0]        ex_funct7
);

  ctrl_t id_ctrl;
  ctrl_t ex_ctrl;
  logic  haz;

  assign id_ctrl = '{alusrc:   id_alusrc,
                     memtoreg: id_memtoreg,
                     regwrite: id_regwrite,
                     memread:  id_memread,
                     memwrite: id_memwrite,
                     aluop:    id_aluop,
                     branch:   id_branch};

  hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
    .ex_memread (ex_ctrl.memread),
    .ex_valid   (ex_valid),
    .ex_rd      (ex_rd),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .ex_flush   (ex_flush),
    .haz        (haz),
    .stall      (stall)
  );

  // Control register: a bubble is all-zero control, which executes as a NOP
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_ctrl  <= CTRL_NOP;
      ex_valid <= 1'b0;
    end else if (ex_flush || haz) begin
      ex_ctrl  <= CTRL_NOP;
      ex_valid <= 1'b0;
    end else begin
      ex_ctrl  <= id_ctrl;
      ex_valid <= 1'b1;
    end
  end

  // Data fields are captured every cycle; their contents only matter when ex_valid
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_pc     <= '0;
      ex_rd1    <= '0;
      ex_rd2    <= '0;
      ex_imm    <= '0;
      ex_rs1    <= '0;
      ex_rs2    <= '0;
      ex_rd     <= '0;
      ex_funct3 <= '0;
      ex_funct7 <= '0;
    end else begin
      ex_pc     <= id_pc;
      ex_rd1    <= id_rd1;
      ex_rd2    <= id_rd2;
      ex_imm    <= id_imm;
      ex_rs1    <= id_rs1;
      ex_rs2    <= id_rs2;
      ex_rd     <= id_rd;
      ex_funct3 <= id_funct3;
      ex_funct7 <= id_funct7;
    end
  end

  assign ex_alusrc   = ex_ctrl.alusrc;
  assign ex_memtoreg = ex_ctrl.memtoreg;
  assign ex_regwrite = ex_ctrl.regwrite;
  assign ex_memread  = ex_ctrl.memread;
  assign ex_memwrite = ex_ctrl.memwrite;
  assign ex_aluop    = ex_ctrl.aluop;
  assign ex_branch   = ex_ctrl.branch;

endmodule
